if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register, the upstream end of the decode-stage interface. Generates fetch addresses and runs a one-outstanding request/response handshake to instruction memory. Latches each returned word with its PC into IF/ID for decode. Decode drives it back through stall, flush and redirect controls (branch and jump targets).

## Interface
- RESET_PC, default 32'h0000_0000: first fetch address after reset.

- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- PC_WriteEnable  in  1  0 = hold fetch PC and issue no new request (hazard stall).
- IFIDWriteEnable  in  1  0 = hold IF/ID contents.
- IFIDFlush  in  1  1 = load IF/ID with NOP, valid=0.
- Branch  in  1  taken-branch redirect.
- BranchDest  in  32  branch target.
- Jump  in  1  jump redirect.
- JumpDest  in  32  jump target.
- IMemReq  out  1  fetch request.
- IMemAddr  out  32  fetch address, word aligned.
- IMemReady  in  1  memory accepts request this cycle.
- IMemRespValid  in  1  response word valid.
- IMemRespData  in  32  response word.
- Instruction  out  32  IF/ID instruction.
- PC  out  32  address of Instruction; decode adds 4 itself.
- IFIDValid  out  1  IF/ID holds a real instruction.

## Operation
- Registers:
  - fpc: next fetch address.
  - tagpc: address of the outstanding request.
  - drop flag.
  - hold buffer {data, pc}.
  - state.
  - IF/ID {Instruction, PC, IFIDValid}.
- States:
  - S_REQ
    - IMemReq = PC_WriteEnable; IMemAddr = fpc.
    - On IMemReq & IMemReady: tagpc <= fpc, fpc <= fpc+4 (mod 2^32, wraps), → S_WAIT.
  - S_WAIT
    - IMemReq = 0.
    - On IMemRespValid with drop=1: discard the word, clear drop, → S_REQ.
    - On IMemRespValid, otherwise, with IFIDWriteEnable=1 and IFIDFlush=0: IF/ID <= {data, tagpc, 1}, → S_REQ.
    - On IMemRespValid, otherwise, when stalled: hold buffer <= {data, tagpc}, → S_HOLD.
  - S_HOLD
    - IMemReq = 0.
    - When IFIDWriteEnable=1 and IFIDFlush=0: IF/ID <= buffer, valid=1, → S_REQ.
- Redirect: redirect = (Branch|Jump) & PC_WriteEnable.
  - Target is JumpDest if Jump=1, else BranchDest; Jump wins if both are set.
  - fpc <= target, overriding the +4.
  - In S_REQ with a request accepted the same cycle: drop <= 1, → S_WAIT.
  - In S_REQ otherwise: stay in S_REQ.
  - In S_WAIT with no response this cycle: drop <= 1.
  - In S_WAIT with a response this cycle: discard it, → S_REQ.
  - In S_HOLD: discard the buffer, → S_REQ.
  - Branch/Jump with PC_WriteEnable=0 is ignored; decode re-presents it.
- IF/ID update priority:
  1. IFIDFlush: Instruction <= 32'h0 (NOP), IFIDValid <= 0, PC unchanged.
  2. IFIDWriteEnable=0: hold.
  3. Load from response or buffer.
  4. Otherwise: IFIDValid <= 0 (bubble), Instruction <= NOP.
- Only one request is ever outstanding. Responses arriving outside S_WAIT are protocol errors; they are ignored, and the bench flags them.

## Timing
- Reset asserted (async):
  - state=S_REQ, fpc=RESET_PC, drop=0.
  - Instruction=0, PC=0, IFIDValid=0.
  - IMemReq forced 0 while Reset=0; IMemAddr=RESET_PC.
- First request: first cycle after Reset deassertion.
- Latency: with IMemReady=1 at cycle t and IMemRespValid at t+1, Instruction/IFIDValid are visible at t+2.
- Throughput with 1-cycle memory: one instruction per 2 cycles.
- Redirect at cycle t: IMemAddr = target at t+1 if no request is outstanding; otherwise one cycle after the stale response is discarded.
- Flush and redirect are normally simultaneous, since decode flushes IF/ID on every branch or jump. The discard of the in-flight word and the NOP load both occur at the same edge.
- Reset mid-transaction: state is abandoned and drop is cleared; a late response from the old transaction is ignored (state S_REQ).

## Structure
- Shared pipeline package:
  - state enum {S_REQ, S_WAIT, S_HOLD}.
  - NOP constant 32'h0.
  - default RESET_PC.
- Sub-module if_id_register holds {Instruction, PC, valid} with write-enable, flush and async active-low reset. It is reused for later stage registers.

## Test plan
- Reset release, IMemReady=1, 1-cycle memory returning addr-as-data → IF/ID shows PC 0,4,8 with Instruction 0,4,8 every 2 cycles, IFIDValid pulsing.
- IFIDWriteEnable=0 for 5 cycles while a response arrives → word held in S_HOLD, IMemReq=0; IF/ID loads it on the first cycle enable returns, and the next request follows.
- Branch=1, BranchDest=32'h100 while a request to 0x8 is outstanding → 0x8 response discarded, next IMemAddr=0x100, IF/ID shows NOP/valid=0.
- Jump=1 and Branch=1 together, JumpDest=0x200, BranchDest=0x300 → fetch resumes at 0x200.
- Branch=1 with PC_WriteEnable=0 → no redirect, no new request, fpc unchanged.
- Reset asserted while in S_WAIT, then a late IMemRespValid → response ignored; IF/ID=0; refetch from RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the pipeline stage registers:
// fetch FSM states, the NOP encoding, the default reset PC and the redirect target helper.
package if_fetch_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Jump wins over branch; targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] redirect_target(
        input logic            jump,
        input logic [XLEN-1:0] jump_dest,
        input logic [XLEN-1:0] branch_dest
    );
        logic [XLEN-1:0] t;
        t = jump ? jump_dest : branch_dest;
        return {t[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_register.sv
// Generic stage register {instruction, pc, valid}: flush beats hold, hold beats load,
// and a cycle with nothing to load inserts a bubble.
module if_id_register
    import if_fetch_stage_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [DATA_W-1:0] load_pc,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= DATA_W'(NOP);
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= DATA_W'(NOP);
            valid <= 1'b0;
        end else if (we) begin
            if (load) begin
                instr <= load_instr;
                pc    <= load_pc;
                valid <= 1'b1;
            end else begin
                instr <= DATA_W'(NOP);
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch with a single outstanding memory request, a one-word hold buffer
// for responses that arrive while decode is stalled, and the IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            PC_WriteEnable,
    input  logic            IFIDWriteEnable,
    input  logic            IFIDFlush,
    input  logic            Branch,
    input  logic [XLEN-1:0] BranchDest,
    input  logic            Jump,
    input  logic [XLEN-1:0] JumpDest,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemReady,
    input  logic            IMemRespValid,
    input  logic [XLEN-1:0] IMemRespData,
    output logic [XLEN-1:0] Instruction,
    output logic [XLEN-1:0] PC,
    output logic            IFIDValid
);

    fetch_state_t    state;
    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] tagpc;
    logic            drop;
    logic [XLEN-1:0] hold_data;
    logic [XLEN-1:0] hold_pc;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            can_take;
    logic            resp_ok;
    logic            resp_take;
    logic            hold_take;
    logic            load;
    logic [XLEN-1:0] load_instr;
    logic [XLEN-1:0] load_pc;

    assign redirect = (Branch | Jump) & PC_WriteEnable;
    assign target   = redirect_target(Jump, JumpDest, BranchDest);

    // Request is gated by reset so nothing is issued while the stage is held in reset.
    assign IMemReq  = Reset & PC_WriteEnable & (state == S_REQ);
    assign IMemAddr = fpc;
    assign accept   = IMemReq & IMemReady;

    assign can_take  = IFIDWriteEnable & ~IFIDFlush;
    assign resp_ok   = (state == S_WAIT) & IMemRespValid & ~drop & ~redirect;
    assign resp_take = resp_ok & can_take;
    assign hold_take = (state == S_HOLD) & ~redirect & can_take;
    assign load      = resp_take | hold_take;
    assign load_instr = hold_take ? hold_data : IMemRespData;
    assign load_pc    = hold_take ? hold_pc   : tagpc;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_REQ;
            fpc   <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            if (redirect)
                fpc <= target;
            else if (accept)
                fpc <= fpc + 32'd4;

            case (state)
                S_REQ: begin
                    if (accept) begin
                        state <= S_WAIT;
                        drop  <= redirect;
                    end
                end
                S_WAIT: begin
                    if (IMemRespValid) begin
                        drop <= 1'b0;
                        if (drop | redirect | can_take)
                            state <= S_REQ;
                        else
                            state <= S_HOLD;
                    end else if (redirect) begin
                        drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect | can_take)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Address tag and hold buffer are pure data and carry no reset.
    always_ff @(posedge Clock) begin
        if (accept)
            tagpc <= fpc;
        if (resp_ok & ~can_take) begin
            hold_data <= IMemRespData;
            hold_pc   <= tagpc;
        end
    end

    if_id_register #(
        .DATA_W (XLEN)
    ) u_if_id (
        .clk        (Clock),
        .rst_n      (Reset),
        .we         (IFIDWriteEnable),
        .flush      (IFIDFlush),
        .load       (load),
        .load_instr (load_instr),
        .load_pc    (load_pc),
        .instr      (Instruction),
        .pc         (PC),
        .valid      (IFIDValid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a transaction-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_if_fetch_stage;

    logic        Clock;
    logic        Reset;
    logic        PC_WriteEnable;
    logic        IFIDWriteEnable;
    logic        IFIDFlush;
    logic        Branch;
    logic [31:0] BranchDest;
    logic        Jump;
    logic [31:0] JumpDest;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic        IMemRespValid;
    logic [31:0] IMemRespData;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        IFIDValid;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ignored = 0;

    bit          auto_mem;
    bit          last_pend;
    logic [31:0] last_addr;

    // Model state: fetch pointer, outstanding request, stale marker, held word, IF/ID.
    logic [31:0] m_fpc;
    bit          m_out;
    logic [31:0] m_out_addr;
    bit          m_stale;
    bit          m_held;
    logic [31:0] m_hd, m_hp;
    logic [31:0] m_instr, m_pc;
    bit          m_valid;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .PC_WriteEnable  (PC_WriteEnable),
        .IFIDWriteEnable (IFIDWriteEnable),
        .IFIDFlush       (IFIDFlush),
        .Branch          (Branch),
        .BranchDest      (BranchDest),
        .Jump            (Jump),
        .JumpDest        (JumpDest),
        .IMemReq         (IMemReq),
        .IMemAddr        (IMemAddr),
        .IMemReady       (IMemReady),
        .IMemRespValid   (IMemRespValid),
        .IMemRespData    (IMemRespData),
        .Instruction     (Instruction),
        .PC              (PC),
        .IFIDValid       (IFIDValid)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fpc = 32'h0; m_out = 0; m_out_addr = 32'h0; m_stale = 0;
        m_held = 0; m_hd = 32'h0; m_hp = 32'h0;
        m_instr = 32'h0; m_pc = 32'h0; m_valid = 0;
    endtask

    task automatic model_edge();
        bit redir, acc, resp, avail, take;
        logic [31:0] tgt, w_data, w_pc;
        redir = (Branch || Jump) && PC_WriteEnable;
        tgt   = Jump ? JumpDest : BranchDest;
        acc   = !m_out && !m_held && PC_WriteEnable && IMemReady;
        resp  = IMemRespValid && m_out;
        if (IMemRespValid && !m_out) n_ignored++;
        take  = IFIDWriteEnable && !IFIDFlush;
        avail = 0; w_data = 32'h0; w_pc = 32'h0;
        if (resp && !m_stale && !redir) begin
            avail = 1; w_data = IMemRespData; w_pc = m_out_addr;
        end else if (m_held && !redir) begin
            avail = 1; w_data = m_hd; w_pc = m_hp;
        end
        if (IFIDFlush) begin
            m_instr = 32'h0; m_valid = 0;
        end else if (IFIDWriteEnable) begin
            if (avail) begin m_instr = w_data; m_pc = w_pc; m_valid = 1; end
            else begin m_instr = 32'h0; m_valid = 0; end
        end
        if (m_held && (redir || take)) m_held = 0;
        if (resp) begin
            if (avail && !take) begin m_held = 1; m_hd = w_data; m_hp = w_pc; end
            m_out = 0; m_stale = 0;
        end else if (m_out && redir) begin
            m_stale = 1;
        end
        if (acc) begin m_out = 1; m_out_addr = m_fpc; m_stale = redir; end
        m_fpc = redir ? tgt : (acc ? m_fpc + 32'd4 : m_fpc);
    endtask

    task automatic model_compare();
        bit exp_req;
        if (!Reset) model_reset();
        exp_req = Reset && !m_out && !m_held && PC_WriteEnable;
        check("m_IMemReq", IMemReq, exp_req);
        if (exp_req || !Reset) check("m_IMemAddr", IMemAddr, m_fpc);
        check("m_Instruction", Instruction, m_instr);
        check("m_PC", PC, m_pc);
        check("m_IFIDValid", IFIDValid, m_valid);
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(Clock);
            if (Clock) begin
                if (Reset) model_edge();
            end else begin
                model_compare();
            end
        end
    end

    // One cycle; the memory answers one cycle after each accepted request when auto_mem is set.
    task automatic tick();
        @(negedge Clock);
        last_pend = IMemReq && IMemReady;
        last_addr = IMemAddr;
        @(posedge Clock);
        #1;
        if (auto_mem) begin
            IMemRespValid = last_pend;
            IMemRespData  = last_addr;
        end
    endtask

    task automatic run_until_accept(input logic [31:0] addr);
        bit got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = last_pend && (last_addr == addr);
        end
        check($sformatf("accept_at_%h", addr), {31'b0, got}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] seen[$];
        Reset = 0; PC_WriteEnable = 1; IFIDWriteEnable = 1; IFIDFlush = 0;
        Branch = 0; BranchDest = 32'h0; Jump = 0; JumpDest = 32'h0;
        IMemReady = 1; IMemRespValid = 0; IMemRespData = 32'h0; auto_mem = 1;

        repeat (2) tick();
        check("rst_IMemReq", {31'b0, IMemReq}, 32'd0);
        check("rst_IMemAddr", IMemAddr, 32'h0);
        check("rst_Instruction", Instruction, 32'h0);
        check("rst_PC", PC, 32'h0);
        check("rst_IFIDValid", {31'b0, IFIDValid}, 32'd0);

        // Streaming with a 1-cycle memory returning the address as data.
        Reset = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (IFIDValid) begin
                seen.push_back(PC);
                check("stream_instr_eq_pc", Instruction, PC);
            end
        end
        check("stream_count", seen.size(), 32'd4);
        for (int i = 0; i < 3; i++)
            check($sformatf("stream_pc%0d", i), (seen.size() > i) ? seen[i] : 32'hFFFF_FFFF, 32'(i * 4));

        // Decode stall while the response to 0x10 arrives.
        run_until_accept(32'h10);
        IFIDWriteEnable = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("stall_no_req", {31'b0, IMemReq}, 32'd0);
            tick();
        end
        check("stall_no_req_last", {31'b0, IMemReq}, 32'd0);
        IFIDWriteEnable = 1;
        tick();
        check("stall_release_valid", {31'b0, IFIDValid}, 32'd1);
        check("stall_release_pc", PC, 32'h10);
        check("stall_release_instr", Instruction, 32'h10);
        check("stall_next_req", {31'b0, IMemReq}, 32'd1);
        check("stall_next_addr", IMemAddr, 32'h14);

        // Branch while the request to 0x8 is answered.
        Reset = 0;
        tick();
        Reset = 1;
        run_until_accept(32'h8);
        Branch = 1; BranchDest = 32'h100; IFIDFlush = 1;
        tick();
        Branch = 0; IFIDFlush = 0;
        check("br_valid", {31'b0, IFIDValid}, 32'd0);
        check("br_instr_nop", Instruction, 32'h0);
        check("br_req", {31'b0, IMemReq}, 32'd1);
        check("br_addr", IMemAddr, 32'h100);
        run_until_accept(32'h100);
        tick();
        check("br_load_pc", PC, 32'h100);
        check("br_load_valid", {31'b0, IFIDValid}, 32'd1);

        // Jump and branch together while a request is still unanswered.
        run_until_accept(32'h104);
        auto_mem = 0; IMemRespValid = 0;
        Jump = 1; JumpDest = 32'h200; Branch = 1; BranchDest = 32'h300; IFIDFlush = 1;
        tick();
        Jump = 0; Branch = 0; IFIDFlush = 0;
        check("jmp_wait_no_req", {31'b0, IMemReq}, 32'd0);
        IMemRespValid = 1; IMemRespData = 32'hBAD0_0104;
        tick();
        IMemRespValid = 0; auto_mem = 1;
        check("jmp_req", {31'b0, IMemReq}, 32'd1);
        check("jmp_addr", IMemAddr, 32'h200);
        check("jmp_discard_valid", {31'b0, IFIDValid}, 32'd0);
        run_until_accept(32'h200);
        tick();
        check("jmp_load_pc", PC, 32'h200);

        // Branch presented while the PC is frozen is ignored.
        PC_WriteEnable = 0; Branch = 1; BranchDest = 32'h300;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("frz_no_req", {31'b0, IMemReq}, 32'd0);
            tick();
        end
        Branch = 0; PC_WriteEnable = 1;
        #1;
        check("frz_req", {31'b0, IMemReq}, 32'd1);
        check("frz_addr", IMemAddr, 32'h204);

        // Reset in the middle of a transaction, then a late response.
        run_until_accept(32'h204);
        auto_mem = 0; IMemRespValid = 0;
        Reset = 0;
        #1;
        check("mid_rst_req", {31'b0, IMemReq}, 32'd0);
        check("mid_rst_addr", IMemAddr, 32'h0);
        check("mid_rst_instr", Instruction, 32'h0);
        check("mid_rst_pc", PC, 32'h0);
        check("mid_rst_valid", {31'b0, IFIDValid}, 32'd0);
        tick();
        Reset = 1; IMemRespValid = 1; IMemRespData = 32'hDEAD_BEEF; auto_mem = 1;
        tick();
        check("late_resp_valid", {31'b0, IFIDValid}, 32'd0);
        check("late_resp_instr", Instruction, 32'h0);
        tick();
        check("refetch_valid", {31'b0, IFIDValid}, 32'd1);
        check("refetch_pc", PC, 32'h0);
        check("refetch_instr", Instruction, 32'h0);
        tick();

        if (n_ignored != 0)
            $display("note: %0d response(s) arrived with no request outstanding and were ignored", n_ignored);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
